matrix_frame_painter: RTL and testbench
=======================================

// Module: matrix_frame_painter
// PURPOSE
//  Wishbone (pipelined, classic-B4 style) master that feeds the 8x8 RGB matrix driver.
//  Generates one of four animated test patterns and writes all 8 row registers (addr 0..7) once per frame.
//  Each row is 8 nibbles 0bxRGB; column 0 sits in bits [31:28], column 7 in bits [3:0].
//  Sits directly upstream of the matrix driver's slave port; one outstanding transaction at a time.
// PARAMETERS
//  WB_DATA_WIDTH  32          data bus width; only 32 is supported
//  WB_ADDR_WIDTH  3           row address width (8 rows)
//  WB_SEL_WIDTH   4           WB_DATA_WIDTH/8
//  FRAME_TICKS    1_000_000   clk cycles from one frame start to the next frame start (>= 64)
//  ACK_TIMEOUT    16          max clk cycles from strobe acceptance to i_wb_ack before abort
// PORTS
//  clk          in   1   system clock; all logic rising-edge
//  reset        in   1   synchronous, active-high reset
//  i_enable     in   1   1 = paint frames; 0 = finish the current frame, then stay idle
//  i_pattern    in   2   pattern select, sampled at each frame start
//  o_wb_cyc     out  1   bus cycle active
//  o_wb_stb     out  1   strobe; held until accepted (i_wb_stall == 0)
//  o_wb_we      out  1   always 1 while o_wb_stb is high
//  o_wb_addr    out  3   row index 0..7
//  o_wb_sel     out  4   always 4'hF while o_wb_stb is high
//  o_wb_wdata   out  32  row word
//  i_wb_ack     in   1   slave acknowledge
//  i_wb_stall   in   1   slave stall
//  o_busy       out  1   1 from frame start until the frame completes or aborts
//  o_frame_done out  1   1-cycle pulse after the row-7 ack
//  o_err        out  1   sticky ack-timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; frame counter f = 0; row r = 0; frame timer = 0; err = 0.
//  States: IDLE -> STB -> ACK -> (STB for next row | DONE) -> WAIT -> STB ...
//  IDLE: when i_enable = 1, on the next cycle latch pattern, set r = 0, load timer = FRAME_TICKS-1, enter STB.
//  STB: cyc=stb=1, addr=r, wdata=pattern(r,f); all bus outputs held stable while i_wb_stall = 1.
//   Accepted on a cycle with stb & !stall -> next cycle stb=0, cyc stays 1, enter ACK, clear ack timer.
//  ACK: wait for i_wb_ack. An ack in the acceptance cycle itself is ignored (slave acks >= 1 cycle later).
//   On ack: r<7 -> r+1, back to STB next cycle (cyc stays 1). r==7 -> cyc=0, DONE.
//   No ack within ACK_TIMEOUT cycles: cyc=0, o_err=1, abort frame (f unchanged, no done pulse), go to WAIT.
//  DONE: o_frame_done=1 for one cycle; f <= f+1 (8-bit, wraps 255->0); go to WAIT.
//  WAIT: o_busy=0; timer decrements every cycle from frame start. At timer==0: i_enable ? new frame : IDLE.
//   If the frame outlasts FRAME_TICKS, the next frame starts on the cycle after DONE/abort.
//  i_enable falling mid-frame does not truncate the frame; i_pattern changes mid-frame are ignored.
//  Patterns, nibble n(r,c) for column c 0..7, k = f[2:0], all arithmetic mod 8:
//   0 SOLID:   n = {1'b0, k}                         (k==0 -> all off)
//   1 DIAG:    n = (c == r+k) ? 4'h7 : 4'h0
//   2 CHECKER: n = ((r^c^f[0]) & 1) ? 4'h4 : 4'h1
//   3 BARS:    n = {1'b0, (c+k)[2:0]}
//  Row word = {n(r,0), n(r,1), ..., n(r,7)}; computed from registered r/f, no bus-visible latency.
//  Reset mid-transaction: cyc/stb drop on the next edge, regardless of pending ack.
// TESTING
//  Zero-wait slave (stall=0, ack 1 cycle after accept), pattern 0, f=0 -> 8 writes addr 0..7, wdata 32'h0, one done pulse.
//  Pattern 1, second frame (f=1) -> row 0 wdata 32'h07000000, row 7 wdata 32'h70000000.
//  Pattern 2 frame 0 -> row 0 32'h14141414, row 1 32'h41414141; stall=1 for 3 cycles holds addr/wdata stable.
//  FRAME_TICKS=64: three frames start exactly 64 cycles apart; f = 0,1,2; o_busy low between frames.
//  Slave never acks on row 3 -> after ACK_TIMEOUT cycles cyc=0, o_err=1 sticky, no done pulse; next frame restarts at row 0.
//  Drop i_enable during row 2 -> rows 3..7 still written, done pulses, block returns to IDLE; reset mid-STB -> all outputs 0 next cycle.

Source files
------------

// File: rtl/matrix_frame_painter.sv
// Wishbone pipelined write master that paints animated 8x8 RGB test patterns
// into the matrix driver's row registers, one full frame per frame period.
module matrix_frame_painter #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 3,
    parameter int WB_SEL_WIDTH  = 4,
    parameter int FRAME_TICKS   = 1_000_000,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_enable,
    input  logic [1:0]               i_pattern,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [WB_ADDR_WIDTH-1:0] o_wb_addr,
    output logic [WB_SEL_WIDTH-1:0]  o_wb_sel,
    output logic [WB_DATA_WIDTH-1:0] o_wb_wdata,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_stall,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic                     o_err
);

    localparam int TW = $clog2(FRAME_TICKS);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STB  = 3'd1,
        S_ACK  = 3'd2,
        S_DONE = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    // Row word for pattern pat at row r of frame f; column 0 lands in the top nibble.
    function automatic logic [31:0] row_word(input logic [1:0] pat,
                                             input logic [2:0] r,
                                             input logic [7:0] f);
        logic [31:0] w;
        logic [2:0]  k;
        logic [2:0]  c;
        logic [3:0]  n;
        w = 32'h0;
        k = f[2:0];
        for (int i = 0; i < 8; i++) begin
            c = 3'(i);
            case (pat)
                2'd0:    n = {1'b0, k};
                2'd1:    n = (c == 3'(r + k)) ? 4'h7 : 4'h0;
                2'd2:    n = (r[0] ^ c[0] ^ f[0]) ? 4'h4 : 4'h1;
                2'd3:    n = {1'b0, 3'(c + k)};
                default: n = 4'h0;
            endcase
            w[31 - 4*i -: 4] = n;
        end
        return w;
    endfunction

    state_t                     state_q, state_d;
    logic [1:0]                 pat_q, pat_d;
    logic [2:0]                 r_q, r_d;
    logic [7:0]                 f_q, f_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic [AW-1:0]              ack_cnt_q, ack_cnt_d;
    logic                       cyc_q, cyc_d;
    logic                       stb_q, stb_d;
    logic [WB_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       start_frame;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        r_d         = r_q;
        f_d         = f_q;
        ack_cnt_d   = ack_cnt_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        start_frame = 1'b0;
        // The frame timer runs freely from each frame start and parks at zero.
        timer_d     = (timer_q != '0) ? timer_q - TW'(1) : '0;

        case (state_q)
            S_IDLE: begin
                if (i_enable) begin
                    start_frame = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STB: begin
                if (!i_wb_stall) begin
                    stb_d     = 1'b0;
                    ack_cnt_d = '0;
                    state_d   = S_ACK;
                end else begin
                    stb_d = 1'b1;
                end
            end
            S_ACK: begin
                if (i_wb_ack) begin
                    if (r_q != 3'd7) begin
                        r_d     = r_q + 3'd1;
                        stb_d   = 1'b1;
                        state_d = S_STB;
                    end else begin
                        cyc_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
                    cyc_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    ack_cnt_d = ack_cnt_q + AW'(1);
                end
            end
            S_DONE: begin
                f_d     = f_q + 8'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (timer_q == '0) begin
                    if (i_enable) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (start_frame) begin
            pat_d   = i_pattern;
            r_d     = 3'd0;
            timer_d = TW'(FRAME_TICKS - 1);
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = S_STB;
        end else begin
            start_frame = 1'b0;
        end

        // Bus data is registered from next-cycle row/frame so it appears with stb.
        wdata_d = stb_d ? WB_DATA_WIDTH'(row_word(pat_d, r_d, f_d)) : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pat_q     <= 2'd0;
            r_q       <= 3'd0;
            f_q       <= 8'd0;
            timer_q   <= '0;
            ack_cnt_q <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            r_q       <= r_d;
            f_q       <= f_d;
            timer_q   <= timer_d;
            ack_cnt_q <= ack_cnt_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign o_wb_cyc     = cyc_q;
    assign o_wb_stb     = stb_q;
    assign o_wb_we      = stb_q;
    assign o_wb_addr    = WB_ADDR_WIDTH'(r_q);
    assign o_wb_sel     = {WB_SEL_WIDTH{stb_q}};
    assign o_wb_wdata   = wdata_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_matrix_frame_painter.sv
// Directed bench for matrix_frame_painter: a scripted Wishbone slave logs writes
// and timing while the main thread checks them against hand-computed values.
module tb_matrix_frame_painter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_enable = 1'b0;
    logic [1:0]  i_pattern = 2'd0;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [2:0]  o_wb_addr;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_wdata;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_stall = 1'b0;
    logic        o_busy, o_frame_done, o_err;

    always #5 clk = ~clk;

    matrix_frame_painter #(
        .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(3), .WB_SEL_WIDTH(4),
        .FRAME_TICKS(64), .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_pattern(i_pattern),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_sel(o_wb_sel), .o_wb_wdata(o_wb_wdata),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .o_busy(o_busy),
        .o_frame_done(o_frame_done), .o_err(o_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Slave scripting and observation log
    int          stall_row = -1;
    int          stall_left = 0;
    int          noack_row = -1;
    bit          acc_prev = 1'b0;
    bit          cyc_prev = 1'b0;
    int          addr_prev = 0;
    int          cyc_n = 0;
    int          n_done = 0;
    int          fall_cyc = 0;
    int          row3_acc = 0;
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          starts[$];
    int          st_addr[$];
    logic [31:0] st_data[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (n_done < target && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(n_done >= target), 32'd1);
    endtask

    // Slave: decides stall and ack on the falling edge, logs accepted writes.
    initial begin
        bit acc;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (o_wb_stb && stall_left > 0 && int'(o_wb_addr) == stall_row) begin
                i_wb_stall = 1'b1;
                stall_left--;
                st_addr.push_back(int'(o_wb_addr));
                st_data.push_back(o_wb_wdata);
            end else begin
                i_wb_stall = 1'b0;
            end
            acc = o_wb_stb && !i_wb_stall;
            i_wb_ack = acc_prev && (addr_prev != noack_row);
            if (acc) begin
                wr_addr.push_back(int'(o_wb_addr));
                wr_data.push_back(o_wb_wdata);
                if (int'(o_wb_addr) == noack_row) row3_acc = cyc_n;
            end
            if (o_wb_cyc && !cyc_prev) starts.push_back(cyc_n);
            if (cyc_prev && !o_wb_cyc) fall_cyc = cyc_n;
            if (o_frame_done) n_done++;
            acc_prev  = acc;
            addr_prev = int'(o_wb_addr);
            cyc_prev  = o_wb_cyc;
        end
    end

    logic [31:0] exp_diag [8] = '{32'h07000000, 32'h00700000, 32'h00070000, 32'h00007000,
                                  32'h00000700, 32'h00000070, 32'h00000007, 32'h70000000};

    initial begin
        int          k;
        int          exp_a[$];
        logic [31:0] exp_d[$];

        repeat (3) @(negedge clk);
        check_eq("rst_cyc",   32'(o_wb_cyc), 32'd0);
        check_eq("rst_stb",   32'(o_wb_stb), 32'd0);
        check_eq("rst_we",    32'(o_wb_we), 32'd0);
        check_eq("rst_sel",   32'(o_wb_sel), 32'd0);
        check_eq("rst_addr",  32'(o_wb_addr), 32'd0);
        check_eq("rst_wdata", o_wb_wdata, 32'h0);
        check_eq("rst_busy",  32'(o_busy), 32'd0);
        check_eq("rst_done",  32'(o_frame_done), 32'd0);
        check_eq("rst_err",   32'(o_err), 32'd0);
        reset = 1'b0;

        // Frame 0: solid, f=0
        @(negedge clk);
        i_enable = 1'b1;
        wait_done(1, "frame0_done");
        repeat (3) @(negedge clk);
        check_eq("done_pulse_once", 32'(n_done), 32'd1);
        check_eq("gap_busy", 32'(o_busy), 32'd0);
        check_eq("gap_cyc",  32'(o_wb_cyc), 32'd0);
        i_pattern = 2'd1;

        // Frame 1: diagonal, f=1
        wait_done(2, "frame1_done");
        i_pattern  = 2'd2;
        stall_row  = 1;
        stall_left = 3;

        // Frame 2: checker with a 3-cycle stall on row 1
        wait_done(3, "frame2_done");
        i_pattern = 2'd0;
        noack_row = 3;

        // Frame 3: slave never acks row 3
        k = 0;
        while (!o_err && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("abort_err", 32'(o_err), 32'd1);
        check_eq("abort_cyc", 32'(o_wb_cyc), 32'd0);
        check_eq("abort_latency", 32'(fall_cyc - row3_acc), 32'd17);
        noack_row = -1;
        i_pattern = 2'd3;

        // Frame 4: bars; enable drops while row 2 is on the bus
        k = 0;
        while (!(o_wb_stb && o_wb_addr == 3'd2) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("frame4_row2_seen", 32'(o_wb_stb && o_wb_addr == 3'd2), 32'd1);
        check_eq("mid_frame_busy", 32'(o_busy), 32'd1);
        i_enable = 1'b0;
        wait_done(4, "frame4_done");
        check_eq("no_done_on_abort", 32'(n_done), 32'd4);
        repeat (100) @(negedge clk);
        check_eq("idle_starts", 32'(starts.size()), 32'd5);
        check_eq("idle_cyc",  32'(o_wb_cyc), 32'd0);
        check_eq("idle_busy", 32'(o_busy), 32'd0);
        check_eq("err_sticky", 32'(o_err), 32'd1);

        // Expected write log across frames 0..4
        for (int r = 0; r < 8; r++) begin exp_a.push_back(r); exp_d.push_back(32'h0); end
        for (int r = 0; r < 8; r++) begin exp_a.push_back(r); exp_d.push_back(exp_diag[r]); end
        for (int r = 0; r < 8; r++) begin
            exp_a.push_back(r);
            exp_d.push_back((r % 2 == 0) ? 32'h14141414 : 32'h41414141);
        end
        for (int r = 0; r < 4; r++) begin exp_a.push_back(r); exp_d.push_back(32'h33333333); end
        for (int r = 0; r < 8; r++) begin exp_a.push_back(r); exp_d.push_back(32'h34567012); end
        check_eq("write_count", 32'(wr_addr.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < wr_addr.size(); i++) begin
            check_eq($sformatf("wr%0d_addr", i), 32'(wr_addr[i]), 32'(exp_a[i]));
            check_eq($sformatf("wr%0d_data", i), wr_data[i], exp_d[i]);
        end

        if (starts.size() >= 5) begin
            check_eq("period_0_1", 32'(starts[1] - starts[0]), 32'd64);
            check_eq("period_1_2", 32'(starts[2] - starts[1]), 32'd64);
            check_eq("period_3_4", 32'(starts[4] - starts[3]), 32'd64);
        end
        check_eq("stall_cycles", 32'(st_addr.size()), 32'd3);
        for (int i = 0; i < st_addr.size(); i++) begin
            check_eq($sformatf("stall%0d_addr", i), 32'(st_addr[i]), 32'd1);
            check_eq($sformatf("stall%0d_data", i), st_data[i], 32'h41414141);
        end

        // Reset while a strobe is pending
        i_enable = 1'b1;
        k = 0;
        while (!o_wb_stb && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("pre_reset_stb", 32'(o_wb_stb), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_cyc",   32'(o_wb_cyc), 32'd0);
        check_eq("mid_rst_stb",   32'(o_wb_stb), 32'd0);
        check_eq("mid_rst_busy",  32'(o_busy), 32'd0);
        check_eq("mid_rst_err",   32'(o_err), 32'd0);
        check_eq("mid_rst_wdata", o_wb_wdata, 32'h0);
        check_eq("mid_rst_sel",   32'(o_wb_sel), 32'd0);
        i_enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
